// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the hazard/forwarding controller:
//   - forward-select encodings for the EX-stage ALU operand muxes
//   - the scoreboard entry kept for each of the EX, MEM and WB stages
//   - helpers that answer "does this entry write register r" and build a
//     forward select from the MEM/WB match results
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    localparam int SB_ADDR_W = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [SB_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memread;
        logic [SB_ADDR_W-1:0] dest;
        logic [SB_ADDR_W-1:0] rs;
        logic [SB_ADDR_W-1:0] rt;
        logic                 uses_rs;
        logic                 uses_rt;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{
        valid: 1'b0, regwrite: 1'b0, memread: 1'b0,
        dest: 5'd0, rs: 5'd0, rt: 5'd0,
        uses_rs: 1'b0, uses_rt: 1'b0
    };

    // Register 0 is hard-wired, so a write to it is never a producer.
    function automatic logic sb_writes(input sb_entry_t e,
                                       input logic [SB_ADDR_W-1:0] r);
        return e.valid & e.regwrite & (e.dest == r) & (r != REG_ZERO);
    endfunction

    // The younger (MEM) producer holds the newer value, so it wins over WB.
    function automatic logic [1:0] fwd_select(input logic uses,
                                              input logic mem_hit,
                                              input logic wb_hit);
        logic [1:0] sel;
        if (uses && mem_hit) begin
            sel = FWD_EXMEM;
        end else if (uses && wb_hit) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// hazard_sat_counter
// Saturating event counter: counts up by one on each cycle inc_i is high and
// sticks at all-ones instead of wrapping.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset, clears the count
//   inc_i  - increment request for this cycle
//   cnt_o  - current count (registered)
// -----------------------------------------------------------------------------
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard, stall and forwarding control for a 5-stage pipeline.
// A three-entry scoreboard shadows the EX, MEM and WB occupants. From it and
// the decoded ID instruction the block derives:
//   pc_write / ifid_write  - fetch and IF/ID enables (low while stalling)
//   ifid_flush             - squash the IF/ID slot on a jump or taken branch
//   idex_bubble            - inject a NOP into ID/EX on a stall or branch
//   fwd_a / fwd_b          - EX operand forward selects (00 reg, 01 EX/MEM,
//                            10 MEM/WB)
//   stall_cnt / flush_cnt  - saturating performance counters
// Inputs: clk, reset (async, active-low), id_* decoded ID control,
// ex_branch_taken from the EX-stage comparator.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_jump,
    input  logic                  id_jr,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    import pipeline_hazard_ctrl_pkg::*;

    sb_entry_t ex_q;
    sb_entry_t mem_q;
    sb_entry_t wb_q;
    sb_entry_t ex_d;

    logic load_use_s;
    logic jr_stall_s;
    logic stall_s;
    logic jump_s;
    logic stall_inc_s;

    // ID-side hazard detection against the registered scoreboard.
    always_comb begin
        load_use_s = id_valid & ex_q.memread &
                     ((id_uses_rs & sb_writes(ex_q, id_rs)) |
                      (id_uses_rt & sb_writes(ex_q, id_rt)));
        // jr needs rs in ID: any EX producer, or a load still in MEM.
        jr_stall_s = id_valid & id_jr &
                     (sb_writes(ex_q, id_rs) |
                      (mem_q.memread & sb_writes(mem_q, id_rs)));
        stall_s    = load_use_s | jr_stall_s;
        jump_s     = id_valid & (id_jump | id_jr) & ~stall_s;
    end

    // Pipeline control; a taken branch discards the ID instruction, so it
    // overrides any ID-side stall or jump.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
        end else if (jump_s) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b0;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end
    end

    // Entry that moves into EX next cycle: the ID instruction or a bubble.
    always_comb begin
        ex_d = SB_EMPTY;
        if (id_valid && !idex_bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.dest     = id_dest;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.uses_rs  = id_uses_rs;
            ex_d.uses_rt  = id_uses_rt;
        end else begin
            ex_d = SB_EMPTY;
        end
    end

    // Scoreboard shift chain EX -> MEM -> WB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Operand forwarding for the instruction now in EX. A load in MEM cannot
    // feed EX here: the load-use stall already put a bubble between them.
    always_comb begin
        fwd_a = fwd_select(ex_q.uses_rs, sb_writes(mem_q, ex_q.rs),
                           sb_writes(wb_q, ex_q.rs));
        fwd_b = fwd_select(ex_q.uses_rt, sb_writes(mem_q, ex_q.rt),
                           sb_writes(wb_q, ex_q.rt));
    end

    // A stall cycle that a branch overrode is not counted as a stall.
    assign stall_inc_s = reset & stall_s & ~ex_branch_taken;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (stall_inc_s),
        .cnt_o (stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc_i (ifid_flush),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for pipeline_hazard_ctrl: a directed vector table for the documented
// scenarios, randomized traffic against a behavioural model of the pipeline,
// and hand sequences for reset behaviour. A second instance with 3-bit
// counters exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       mr;
        logic       j;
        logic       jr;
        logic       br;
    } ins_t;

    typedef struct {
        ins_t       i;
        logic       pc;
        logic       ifw;
        logic       fl;
        logic       bub;
        logic [1:0] fa;
        logic [1:0] fb;
        int         sc;
        int         fc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic id_jump, id_jr, ex_branch_taken;
    logic [4:0] id_rs, id_rt, id_dest;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    int tests = 0;
    int fails = 0;

    // Model state: instructions that entered EX over the last three cycles
    // (index 0 = newest), plus total stall and flush events seen.
    ins_t hist [3];
    int   stall_n;
    int   flush_n;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_jump(id_jump), .id_jr(id_jr), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_jump(id_jump), .id_jr(id_jr), .ex_branch_taken(ex_branch_taken),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    function automatic ins_t mk(logic v, logic [4:0] rs, logic [4:0] rt,
                                logic urs, logic urt, logic [4:0] dest,
                                logic rw, logic mr, logic j, logic jr,
                                logic br);
        ins_t x;
        x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
        x.dest = dest; x.rw = rw; x.mr = mr; x.j = j; x.jr = jr; x.br = br;
        return x;
    endfunction

    function automatic vec_t mkv(ins_t i, logic pc, logic ifw, logic fl,
                                 logic bub, logic [1:0] fa, logic [1:0] fb,
                                 int sc, int fc);
        vec_t r;
        r.i = i; r.pc = pc; r.ifw = ifw; r.fl = fl; r.bub = bub;
        r.fa = fa; r.fb = fb; r.sc = sc; r.fc = fc;
        return r;
    endfunction

    // Does an instruction that entered the pipe produce register r?
    function automatic bit produces(ins_t e, logic [4:0] r);
        return e.v && e.rw && (e.dest == r) && (r != 5'd0);
    endfunction

    function automatic int sat(int n, int m);
        return (n > m) ? m : n;
    endfunction

    // Where the EX instruction gets a source operand from.
    function automatic logic [1:0] src_of(logic uses, logic [4:0] r);
        if (!uses)                 return 2'd0;
        if (produces(hist[1], r))  return 2'd1;
        if (produces(hist[2], r))  return 2'd2;
        return 2'd0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(ins_t x);
        id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs;
        id_uses_rt = x.urt; id_dest = x.dest; id_regwrite = x.rw;
        id_memread = x.mr; id_jump = x.j; id_jr = x.jr;
        ex_branch_taken = x.br;
    endtask

    task automatic model_clear();
        ins_t n;
        n = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) hist[k] = n;
        stall_n = 0;
        flush_n = 0;
    endtask

    // One pipeline cycle: apply x, compare against the model (and against
    // the hand-written vector when given), then advance the model.
    task automatic step(string tag, ins_t x, bit have_vec, vec_t vv);
        bit lu, jrs, st, jmp, e_pc, e_ifw, e_fl, e_bub;
        logic [1:0] e_fa, e_fb;
        ins_t n;
        @(negedge clk);
        drive(x);
        #1;
        lu  = x.v && hist[0].mr &&
              ((x.urs && produces(hist[0], x.rs)) ||
               (x.urt && produces(hist[0], x.rt)));
        jrs = x.v && x.jr &&
              (produces(hist[0], x.rs) || (hist[1].mr && produces(hist[1], x.rs)));
        st  = lu || jrs;
        jmp = x.v && (x.j || x.jr) && !st;
        e_pc  = x.br || !st;
        e_ifw = x.br || !st;
        e_fl  = x.br || jmp;
        e_bub = x.br || st;
        e_fa  = src_of(hist[0].urs && hist[0].v, hist[0].rs);
        e_fb  = src_of(hist[0].urt && hist[0].v, hist[0].rt);
        chk({tag, " pc_write"},    32'(pc_write),    32'(e_pc));
        chk({tag, " ifid_write"},  32'(ifid_write),  32'(e_ifw));
        chk({tag, " ifid_flush"},  32'(ifid_flush),  32'(e_fl));
        chk({tag, " idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
        chk({tag, " fwd_a"},       32'(fwd_a),       32'(e_fa));
        chk({tag, " fwd_b"},       32'(fwd_b),       32'(e_fb));
        chk({tag, " stall_cnt"},   32'(stall_cnt),   32'(sat(stall_n, 65535)));
        chk({tag, " flush_cnt"},   32'(flush_cnt),   32'(sat(flush_n, 65535)));
        chk({tag, " s_stall_cnt"}, 32'(s_stall_cnt), 32'(sat(stall_n, 7)));
        chk({tag, " s_flush_cnt"}, 32'(s_flush_cnt), 32'(sat(flush_n, 7)));
        if (have_vec) begin
            chk({tag, " vec pc_write"},    32'(pc_write),    32'(vv.pc));
            chk({tag, " vec ifid_write"},  32'(ifid_write),  32'(vv.ifw));
            chk({tag, " vec ifid_flush"},  32'(ifid_flush),  32'(vv.fl));
            chk({tag, " vec idex_bubble"}, 32'(idex_bubble), 32'(vv.bub));
            chk({tag, " vec fwd_a"},       32'(fwd_a),       32'(vv.fa));
            chk({tag, " vec fwd_b"},       32'(fwd_b),       32'(vv.fb));
            chk({tag, " vec stall_cnt"},   32'(stall_cnt),   32'(vv.sc));
            chk({tag, " vec flush_cnt"},   32'(flush_cnt),   32'(vv.fc));
        end
        if (e_fl)               flush_n++;
        if (st && !x.br)        stall_n++;
        n = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = (x.br || st || !x.v) ? n : x;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, " pc_write"},    32'(pc_write),    32'd1);
        chk({tag, " ifid_write"},  32'(ifid_write),  32'd1);
        chk({tag, " ifid_flush"},  32'(ifid_flush),  32'd0);
        chk({tag, " idex_bubble"}, 32'(idex_bubble), 32'd0);
        chk({tag, " fwd_a"},       32'(fwd_a),       32'd0);
        chk({tag, " fwd_b"},       32'(fwd_b),       32'd0);
        chk({tag, " stall_cnt"},   32'(stall_cnt),   32'd0);
        chk({tag, " flush_cnt"},   32'(flush_cnt),   32'd0);
        chk({tag, " s_stall_cnt"}, 32'(s_stall_cnt), 32'd0);
    endtask

    initial begin
        ins_t nop, lw5, add657, add312, sub433, add012, sub400, lw31, jr31, add657b, hot, r;
        vec_t tbl [19];
        vec_t none;

        nop     = mk(1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lw5     = mk(1'b1, 5'd1,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add657  = mk(1'b1, 5'd5,  5'd7, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add312  = mk(1'b1, 5'd1,  5'd2, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sub433  = mk(1'b1, 5'd3,  5'd3, 1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add012  = mk(1'b1, 5'd1,  5'd2, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sub400  = mk(1'b1, 5'd0,  5'd0, 1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        lw31    = mk(1'b1, 5'd1,  5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        jr31    = mk(1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add657b = mk(1'b1, 5'd5,  5'd7, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        hot     = mk(1'b1, 5'd3,  5'd4, 1'b1, 1'b1, 5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        none    = mkv(nop, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0);

        //                ins      pc    ifw   fl    bub   fa    fb    sc fc
        tbl[0]  = mkv(lw5,     1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0);
        tbl[1]  = mkv(add657,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 0, 0);
        tbl[2]  = mkv(add657,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1, 0);
        tbl[3]  = mkv(nop,     1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1, 0);
        tbl[4]  = mkv(add312,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1, 0);
        tbl[5]  = mkv(sub433,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1, 0);
        tbl[6]  = mkv(nop,     1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1, 0);
        tbl[7]  = mkv(add012,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1, 0);
        tbl[8]  = mkv(sub400,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1, 0);
        tbl[9]  = mkv(nop,     1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1, 0);
        tbl[10] = mkv(nop,     1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1, 0);
        tbl[11] = mkv(lw31,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1, 0);
        tbl[12] = mkv(jr31,    1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1, 0);
        tbl[13] = mkv(jr31,    1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2, 0);
        tbl[14] = mkv(jr31,    1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 3, 0);
        tbl[15] = mkv(nop,     1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3, 1);
        tbl[16] = mkv(lw5,     1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3, 1);
        tbl[17] = mkv(add657b, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 3, 1);
        tbl[18] = mkv(nop,     1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3, 2);

        // Reset held for 3 cycles with a jump and a branch on the inputs:
        // the outputs must still show the reset values.
        reset = 1'b0;
        drive(hot);
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("in_reset");
        reset = 1'b1;
        drive(nop);
        #1;
        chk_reset_vals("after_release");

        for (int k = 0; k < 19; k++) begin
            step($sformatf("vec%0d", k), tbl[k].i, 1'b1, tbl[k]);
        end

        // Random traffic over a small register set so hazards are common.
        for (int k = 0; k < 500; k++) begin
            r.v    = ($urandom_range(0, 7) != 0);
            r.rs   = 5'($urandom_range(0, 3));
            r.rt   = 5'($urandom_range(0, 3));
            r.urs  = 1'($urandom_range(0, 1));
            r.urt  = 1'($urandom_range(0, 1));
            r.dest = 5'($urandom_range(0, 3));
            r.mr   = ($urandom_range(0, 2) == 0);
            r.rw   = r.mr || ($urandom_range(0, 1) == 1);
            r.j    = ($urandom_range(0, 9) == 0);
            r.jr   = !r.j && ($urandom_range(0, 7) == 0);
            r.br   = ($urandom_range(0, 7) == 0);
            step($sformatf("rnd%0d", k), r, 1'b0, none);
        end
        chk("small stall_cnt saturated", 32'(s_stall_cnt), 32'(stall_n >= 7 ? 7 : stall_n));
        chk("small flush_cnt saturated", 32'(s_flush_cnt), 32'(flush_n >= 7 ? 7 : flush_n));

        // Reset asserted in the middle of a load-use stall.
        step("pre_lw", nop, 1'b0, none);
        step("pre_lw2", nop, 1'b0, none);
        step("mid_lw", lw5, 1'b0, none);
        @(negedge clk);
        drive(add657);
        #1;
        chk("mid_stall pc_write", 32'(pc_write), 32'd0);
        chk("mid_stall idex_bubble", 32'(idex_bubble), 32'd1);
        reset = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b1;
        drive(nop);
        model_clear();
        #1;
        chk_reset_vals("post_release");
        step("post_add", add657, 1'b1, mkv(add657, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0));
        step("post_nop", nop, 1'b0, none);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard, stall and forwarding controller for the 5-stage pipelined processor. It consumes the decoded control of the instruction in ID, plus the EX-stage branch outcome. It keeps a registered scoreboard of the EX/MEM/WB occupants and drives PC/IF-ID write enables, flushes, ID/EX bubble insertion and the ALU operand forwarding selects. It also keeps saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_ADDR_W  source register A of the ID instruction
id_rt  in  REG_ADDR_W  source register B of the ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  REG_ADDR_W  destination after regdst mux (rd, rt or 31)
id_regwrite  in  1  decoded regwrite
id_memread  in  1  decoded memread
id_jump  in  1  j/jal, resolved in ID
id_jr  in  1  jr, target is rs, resolved in ID
ex_branch_taken  in  1  beq in EX resolved taken
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  load NOP into ID/EX
fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  EX operand B select, same encoding
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flush events

Behaviour:
- Scoreboard: three registered entries EX, MEM, WB. Each entry is {valid, regwrite, memread, dest, rs, rt, uses_rs, uses_rt}.
- Every cycle: WB<=MEM, MEM<=EX. EX <= captured ID fields, or an invalid entry when idex_bubble=1 or id_valid=0.
- Reset: all entries invalid, counters 0. While in reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00.
- An entry "writes r" if valid & regwrite & dest==r & r!=0. Register 0 never hazards and is never forwarded.
- Load-use stall: id_valid and the EX entry is a load (memread) that writes a used source of ID. Response: pc_write=0, ifid_write=0, idex_bubble=1.
- JR stall: id_valid & id_jr and either the EX entry writes id_rs, or the MEM entry is a load writing id_rs. Response: same as load-use stall. The stall holds for as many cycles as the condition holds (at most 2).
- Jump redirect: id_valid & (id_jump | id_jr) and no stall. Response: ifid_flush=1, pc_write=1. Latency is 1 cycle (one squashed slot).
- Branch redirect: ex_branch_taken=1. Response: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1. This has priority over every ID-side stall or jump, because the ID instruction is discarded and its hazards are ignored that cycle.
- Forwarding for the EX entry:
  - fwd_a=01 if MEM writes EX.rs and EX.uses_rs; else 10 if WB writes EX.rs; else 00.
  - fwd_b uses rt the same way.
  - MEM has priority over WB.
  - A MEM-stage load never matches, because the stall guarantees this.
  - Outputs are combinational from scoreboard state.
- Counters:
  - stall_cnt +1 on each stall cycle.
  - flush_cnt +1 on each cycle with ifid_flush=1.
  - Both saturate at all-ones and do not wrap.
- Simultaneous stall and branch: the branch wins, stall_cnt does not increment, and flush_cnt increments once.
- Reset asserted mid-stall: state clears immediately. The first cycle after release is a normal fetch.
- No FSM beyond the scoreboard shift chain. All ID-side outputs are combinational from the ID inputs plus registered state.

Decomposition:
- Shared package holds:
  - the forward-select encoding constants FWD_REG=00, FWD_EXMEM=01, FWD_MEMWB=10;
  - the scoreboard entry typedef;
  - REG_ZERO=0.
- One sub-module, hazard_sat_counter (CNT_W wide, inc input, saturating), instantiated twice.

Test Plan:
- Reset low for 3 cycles, then high, with no instructions -> pc_write=1, ifid_write=1, fwd=00, counters 0.
- lw r5 then add r6,r5,r7 -> exactly 1 stall cycle (pc_write=0, idex_bubble=1). Next cycle fwd_a=10. stall_cnt=1.
- add r3,r1,r2; sub r4,r3,r3 -> no stall, fwd_a=01 and fwd_b=01. Same case with dest r0 -> fwd 00.
- lw r31 then jr r31 -> 2 stall cycles, then ifid_flush=1 for 1 cycle. stall_cnt=2, flush_cnt=1.
- Load-use stall condition and ex_branch_taken=1 in the same cycle -> pc_write=1, ifid_flush=1, idex_bubble=1. stall_cnt unchanged, flush_cnt +1.
- Force stall_cnt to 16'hFFFF, then one more stall -> stays 16'hFFFF. Assert reset mid-stall -> outputs return to reset values asynchronously.
